// File: rtl/haz_pkg.sv
// Shared types and encodings for the scoreboard hazard/forwarding unit:
// operation classes, forward-select codes and fixed retire ages.
package haz_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_ALU   = 3'd1,
      OP_LOAD  = 3'd2,
      OP_STORE = 3'd3,
      OP_MUL   = 3'd4,
      OP_DIV   = 3'd5
   } opclass_t;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXE  = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] FWD_LOAD = 2'b11;

   localparam int ALU_RETIRE_AGE  = 2;
   localparam int LOAD_RETIRE_AGE = 2;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer table (busy/class/age) with retire logic,
// plus a readiness lookup for each of the two ID source operands.
module hazard_scoreboard
   import haz_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int MUL_LAT  = 3,
   parameter int AGE_W    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_i,
   input  logic [REG_AW-1:0] issue_rd_i,
   input  opclass_t          issue_cls_i,
   input  logic              div_done_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic              rs1use_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic              rs2use_i,
   input  logic              store_i,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_a_o,
   output logic              stall_b_o,
   output logic              ls_hit_o
);

   localparam logic [AGE_W-1:0] ALU_LAST_AGE  = AGE_W'(ALU_RETIRE_AGE - 1);
   localparam logic [AGE_W-1:0] LOAD_LAST_AGE = AGE_W'(LOAD_RETIRE_AGE - 1);
   localparam logic [AGE_W-1:0] MUL_LAST_AGE  = AGE_W'(MUL_LAT - 1);
   localparam logic [AGE_W-1:0] AGE_MAX       = '1;

   logic [NUM_REGS-1:0]            busy_vec;
   opclass_t [NUM_REGS-1:0]        cls_vec;
   logic [NUM_REGS-1:0][AGE_W-1:0] age_vec;

   // x0 is hard-wired zero and never has a pending writer
   assign busy_vec[0] = 1'b0;
   assign cls_vec[0]  = OP_NONE;
   assign age_vec[0]  = '0;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
         localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
         logic             busy_q, busy_d;
         opclass_t         cls_q, cls_d;
         logic [AGE_W-1:0] age_q, age_d;
         logic             retire;

         always_comb begin
            unique case (cls_q)
               OP_LOAD: retire = (age_q >= LOAD_LAST_AGE);
               OP_MUL:  retire = (age_q >= MUL_LAST_AGE);
               OP_DIV:  retire = div_done_i;
               default: retire = (age_q >= ALU_LAST_AGE);
            endcase
         end

         // A new writer to this register takes priority over retirement (WAW)
         always_comb begin
            busy_d = busy_q;
            cls_d  = cls_q;
            age_d  = age_q;
            if (issue_i && (issue_rd_i == IDX)) begin
               busy_d = 1'b1;
               cls_d  = issue_cls_i;
               age_d  = '0;
            end else if (busy_q) begin
               if (retire) begin
                  busy_d = 1'b0;
               end else if (age_q != AGE_MAX) begin
                  age_d = age_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               busy_q <= 1'b0;
               cls_q  <= OP_NONE;
               age_q  <= '0;
            end else begin
               busy_q <= busy_d;
               cls_q  <= cls_d;
               age_q  <= age_d;
            end
         end

         assign busy_vec[gi] = busy_q;
         assign cls_vec[gi]  = cls_q;
         assign age_vec[gi]  = age_q;
      end
   endgenerate

   logic [1:0][REG_AW-1:0] rs_idx;
   logic [1:0]             rs_use;
   logic [1:0][1:0]        fwd_all;
   logic [1:0]             stall_all;
   logic [1:0]             ls_all;

   assign rs_idx = {rs2_i, rs1_i};
   assign rs_use = {rs2use_i, rs1use_i};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         localparam bit IS_RS2 = (gi == 1);
         logic [REG_AW-1:0] idx;
         logic              hit;
         logic [1:0]        fwd;
         logic              stl;
         logic              ls;

         always_comb begin
            idx = rs_idx[gi];
            hit = rs_use[gi] && (idx != '0) && busy_vec[idx];
            fwd = FWD_RF;
            stl = 1'b0;
            ls  = 1'b0;
            if (hit) begin
               unique case (cls_vec[idx])
                  OP_LOAD: begin
                     // Store data from a just-issued load is picked up in EXE instead of stalling
                     if (age_vec[idx] == '0) begin
                        if (IS_RS2 && store_i) ls = 1'b1;
                        else                   stl = 1'b1;
                     end else begin
                        fwd = FWD_LOAD;
                     end
                  end
                  OP_MUL: begin
                     if (age_vec[idx] == MUL_LAST_AGE) fwd = FWD_MEM;
                     else                              stl = 1'b1;
                  end
                  OP_DIV: begin
                     if (div_done_i) fwd = FWD_MEM;
                     else            stl = 1'b1;
                  end
                  default: begin
                     fwd = (age_vec[idx] == '0) ? FWD_EXE : FWD_MEM;
                  end
               endcase
            end
         end

         assign fwd_all[gi]   = fwd;
         assign stall_all[gi] = stl;
         assign ls_all[gi]    = ls;
      end
   endgenerate

   assign fwd_a_o   = fwd_all[0];
   assign fwd_b_o   = fwd_all[1];
   assign stall_a_o = stall_all[0];
   assign stall_b_o = stall_all[1];
   assign ls_hit_o  = ls_all[1];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: combines scoreboard readiness with divider occupancy into
// stall/flush/forward controls. HAZ_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_scoreboard_unit
   import haz_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int MUL_LAT  = 3,
   parameter int AGE_W    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_ID,
   input  logic [REG_AW-1:0] rs2_ID,
   input  logic              rs1use_ID,
   input  logic              rs2use_ID,
   input  logic [REG_AW-1:0] rd_ID,
   input  logic              rdwr_ID,
   input  opclass_t          opclass_ID,
   input  logic              Branch_ID,
   input  logic              div_done,
   output logic              PC_EN_IF,
   output logic              reg_FD_stall,
   output logic              reg_FD_flush,
   output logic              reg_DE_flush,
   output logic [1:0]        forward_ctrl_A,
   output logic [1:0]        forward_ctrl_B,
   output logic              forward_ctrl_ls,
   output logic              div_busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   logic stall_a, stall_b, ls_hit;
   logic stall, issue;
   logic div_busy_q, div_busy_d;
   logic st_tag_q, st_tag_d;

   hazard_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW),
      .MUL_LAT  (MUL_LAT),
      .AGE_W    (AGE_W)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_i     (issue),
      .issue_rd_i  (rd_ID),
      .issue_cls_i (opclass_ID),
      .div_done_i  (div_done),
      .rs1_i       (rs1_ID),
      .rs1use_i    (rs1use_ID),
      .rs2_i       (rs2_ID),
      .rs2use_i    (rs2use_ID),
      .store_i     (opclass_ID == OP_STORE),
      .fwd_a_o     (forward_ctrl_A),
      .fwd_b_o     (forward_ctrl_B),
      .stall_a_o   (stall_a),
      .stall_b_o   (stall_b),
      .ls_hit_o    (ls_hit)
   );

   always_comb begin
      stall = stall_a | stall_b | ((opclass_ID == OP_DIV) && div_busy_q);
      issue = !stall && rdwr_ID && (rd_ID != '0);
      div_busy_d = div_busy_q;
      if (!stall && (opclass_ID == OP_DIV)) begin
         div_busy_d = 1'b1;
      end else if (div_done) begin
         div_busy_d = 1'b0;
      end
      // The store moves to EXE next cycle while the load sits in MEM
      st_tag_d = !stall && ls_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_busy_q <= 1'b0;
         st_tag_q   <= 1'b0;
      end else begin
         div_busy_q <= div_busy_d;
         st_tag_q   <= st_tag_d;
      end
   end

   assign PC_EN_IF        = ~stall;
   assign reg_FD_stall    = stall;
   assign reg_DE_flush    = stall;
   // Held low while reset is asserted, even with a taken branch on the inputs
   assign reg_FD_flush    = Branch_ID & ~stall & rst_n;
   assign forward_ctrl_ls = st_tag_q;
   assign div_busy        = div_busy_q;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall)        stall_cnt_q <= stall_cnt_q + 32'd1;
         if (reg_FD_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: one task per scenario, each with its
// own per-cycle stimulus/expected table and inline output comparisons.
module tb_hazard_scoreboard_unit;
   import haz_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_ID, rs2_ID, rd_ID;
   logic       rs1use_ID, rs2use_ID, rdwr_ID, Branch_ID, div_done;
   opclass_t   opclass_ID;
   logic       PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush;
   logic [1:0] forward_ctrl_A, forward_ctrl_B;
   logic       forward_ctrl_ls, div_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs1_ID          (rs1_ID),
      .rs2_ID          (rs2_ID),
      .rs1use_ID       (rs1use_ID),
      .rs2use_ID       (rs2use_ID),
      .rd_ID           (rd_ID),
      .rdwr_ID         (rdwr_ID),
      .opclass_ID      (opclass_ID),
      .Branch_ID       (Branch_ID),
      .div_done        (div_done),
      .PC_EN_IF        (PC_EN_IF),
      .reg_FD_stall    (reg_FD_stall),
      .reg_FD_flush    (reg_FD_flush),
      .reg_DE_flush    (reg_DE_flush),
      .forward_ctrl_A  (forward_ctrl_A),
      .forward_ctrl_B  (forward_ctrl_B),
      .forward_ctrl_ls (forward_ctrl_ls),
      .div_busy        (div_busy)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   // {PC_EN, FD_stall, FD_flush, DE_flush, fwdA, fwdB, ls, div_busy}
   logic [9:0] obs;
   assign obs = {PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush,
                 forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, div_busy};

   typedef struct packed {
      opclass_t   op;
      logic [4:0] rd;
      logic       wr;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       br;
      logic       dd;
   } stim_t;

   function automatic stim_t ins(opclass_t op, int rd, int rs1, int rs2, int br, int dd);
      stim_t s;
      s.op  = op;
      s.rd  = 5'(rd);
      s.wr  = (op == OP_ALU) || (op == OP_LOAD) || (op == OP_MUL) || (op == OP_DIV);
      s.rs1 = 5'(rs1);
      s.u1  = (rs1 != 0);
      s.rs2 = 5'(rs2);
      s.u2  = (rs2 != 0);
      s.br  = 1'(br);
      s.dd  = 1'(dd);
      return s;
   endfunction

   function automatic stim_t nop(int dd);
      return ins(OP_NONE, 0, 0, 0, 0, dd);
   endfunction

   // Expected output vector: a stall also drops PC_EN and bubbles ID/EX
   function automatic logic [9:0] ev(int st, int fl, int fa, int fb, int ls, int bz);
      return {~1'(st), 1'(st), 1'(fl), 1'(st), 2'(fa), 2'(fb), 1'(ls), 1'(bz)};
   endfunction

   task automatic drive(input stim_t s);
      opclass_ID = s.op;
      rd_ID      = s.rd;
      rdwr_ID    = s.wr;
      rs1_ID     = s.rs1;
      rs1use_ID  = s.u1;
      rs2_ID     = s.rs2;
      rs2use_ID  = s.u2;
      Branch_ID  = s.br;
      div_done   = s.dd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(nop(0));
      #3;
      n_checks++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset_early: got %b expected %b", obs, ev(0, 0, 0, 0, 0, 0));
      end else $display("reset_early obs=%b", obs);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs !== ev(0, 0, 0, 0, 0, 0)) begin
         n_errors++;
         $display("FAIL reset_held: got %b expected %b", obs, ev(0, 0, 0, 0, 0, 0));
      end else $display("reset_held obs=%b", obs);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alu_fwd();
      stim_t      s [15];
      logic [9:0] e [15];
      s = '{ins(OP_ALU, 5, 0, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 0, 0), nop(0), nop(0),
            ins(OP_ALU, 5, 0, 0, 0, 0), nop(0), ins(OP_ALU, 7, 0, 5, 0, 0), nop(0), nop(0),
            ins(OP_ALU, 5, 0, 0, 0, 0), nop(0), nop(0), ins(OP_ALU, 6, 5, 0, 0, 0),
            nop(0), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(0,0,1,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,2,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 15; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL alu_fwd[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("alu_fwd[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_waw();
      stim_t      s [6];
      logic [9:0] e [6];
      s = '{ins(OP_ALU, 5, 0, 0, 0, 0), nop(0), ins(OP_ALU, 5, 0, 0, 0, 0),
            ins(OP_ALU, 6, 5, 0, 0, 0), nop(0), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,1,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL waw[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("waw[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_x0_unused();
      stim_t      s [6];
      logic [9:0] e [6];
      s = '{ins(OP_ALU, 0, 0, 0, 0, 0), ins(OP_ALU, 6, 0, 0, 0, 0),
            ins(OP_ALU, 5, 0, 0, 0, 0), ins(OP_ALU, 7, 5, 5, 0, 0), nop(0), nop(0)};
      s[1].u1 = 1'b1;
      s[1].u2 = 1'b1;
      s[3].u1 = 1'b0;
      s[3].u2 = 1'b0;
      e = '{ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL x0_unused[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("x0_unused[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load_use();
      stim_t      s [10];
      logic [9:0] e [10];
      s = '{ins(OP_LOAD, 5, 0, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 0, 0),
            nop(0), nop(0),
            ins(OP_LOAD, 8, 0, 0, 0, 0), ins(OP_ALU, 9, 0, 8, 0, 0), ins(OP_ALU, 9, 0, 8, 0, 0),
            nop(0), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(1,0,0,0,0,0), ev(0,0,3,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(1,0,0,0,0,0), ev(0,0,0,3,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 10; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("load_use[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load_store();
      stim_t      s [9];
      logic [9:0] e [9];
      s = '{ins(OP_LOAD, 5, 0, 0, 0, 0), ins(OP_STORE, 0, 7, 5, 0, 0), nop(0), nop(0),
            ins(OP_LOAD, 5, 0, 0, 0, 0), ins(OP_STORE, 0, 5, 5, 0, 0),
            ins(OP_STORE, 0, 5, 5, 0, 0), nop(0), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,1,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(1,0,0,0,0,0), ev(0,0,3,3,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0)};
      for (int i = 0; i < 9; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL load_store[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("load_store[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_mul();
      stim_t      s [6];
      logic [9:0] e [6];
      s = '{ins(OP_MUL, 5, 0, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 0, 0),
            ins(OP_ALU, 6, 5, 0, 0, 0), nop(0), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(1,0,0,0,0,0), ev(1,0,0,0,0,0),
            ev(0,0,2,0,0,0), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL mul[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("mul[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_div_branch();
      stim_t      s [9];
      logic [9:0] e [9];
      s = '{ins(OP_DIV, 5, 1, 2, 0, 0), ins(OP_DIV, 6, 3, 4, 0, 0), ins(OP_DIV, 6, 3, 4, 0, 0),
            ins(OP_DIV, 6, 3, 4, 0, 1), ins(OP_DIV, 6, 3, 4, 0, 0),
            ins(OP_NONE, 0, 6, 0, 1, 0), ins(OP_NONE, 0, 6, 0, 1, 0),
            ins(OP_NONE, 0, 6, 0, 1, 1), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(1,0,0,0,0,1), ev(1,0,0,0,0,1), ev(1,0,0,0,0,1),
            ev(0,0,0,0,0,0), ev(1,0,0,0,0,1), ev(1,0,0,0,0,1), ev(0,1,2,0,0,1),
            ev(0,0,0,0,0,0)};
      for (int i = 0; i < 9; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL div_branch[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("div_branch[%0d] obs=%b", i, obs);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid_div();
      stim_t      s [8];
      logic [9:0] e [8];
      s = '{ins(OP_DIV, 5, 0, 0, 0, 0), ins(OP_ALU, 6, 5, 0, 1, 0), nop(1),
            ins(OP_ALU, 6, 5, 0, 0, 0), ins(OP_DIV, 7, 0, 0, 0, 0), nop(0), nop(1), nop(0)};
      e = '{ev(0,0,0,0,0,0), ev(1,0,0,0,0,1), ev(0,0,0,0,0,0), ev(0,0,0,0,0,0),
            ev(0,0,0,0,0,0), ev(0,0,0,0,0,1), ev(0,0,0,0,0,1), ev(0,0,0,0,0,0)};
      for (int i = 0; i < 8; i++) begin
         drive(s[i]);
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            n_errors++;
            $display("FAIL reset_mid_div[%0d]: got %b expected %b", i, obs, e[i]);
         end else $display("reset_mid_div[%0d] obs=%b", i, obs);
         if (i == 1) begin
            rst_n = 1'b0;
            #1;
            n_checks++;
            if (obs !== ev(0, 0, 0, 0, 0, 0)) begin
               n_errors++;
               $display("FAIL reset_async: got %b expected %b", obs, ev(0, 0, 0, 0, 0, 0));
            end else $display("reset_async obs=%b", obs);
         end
         @(posedge clk);
         #1;
         if (i == 1) rst_n = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_waw();
      test_x0_unused();
      test_load_use();
      test_load_store();
      test_mul();
      test_div_branch();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
